expr_pipe_eval: RTL and testbench

//  Parametrised, pipelined multi-lane expression evaluator for the vloghammer regression suite.

---
 rtl/expr_pipe_pkg.sv | 35 +++
 rtl/expr_pipe_lane.sv | 68 ++++++
 rtl/expr_pipe_eval.sv | 109 ++++++++++
 tb/tb_expr_pipe_eval.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/expr_pipe_pkg.sv
// Shared definitions for the pipelined expression evaluator: opcodes, sign-flag
// bit positions and the context-width helper.
package expr_pipe_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_XNOR  = 4'd5,
    OP_SHL   = 4'd6,
    OP_SHR   = 4'd7,
    OP_ASHR  = 4'd8,
    OP_LT    = 4'd9,
    OP_GE    = 4'd10,
    OP_EQ    = 4'd11,
    OP_NE    = 4'd12,
    OP_LAND  = 4'd13,
    OP_LOR   = 4'd14,
    OP_RXNOR = 4'd15
  } op_e;

  localparam int SGN_A = 1;
  localparam int SGN_B = 0;

  function automatic int ctx_width(input int wa, input int wb, input int wy);
    int c;
    c = wa;
    if (wb > c) c = wb;
    if (wy > c) c = wy;
    return c;
  endfunction

endpackage

// File: rtl/expr_pipe_lane.sv
// One evaluation lane: resolves the operand context, computes the selected
// expression at context width and truncates to the result width.
module expr_pipe_lane
  import expr_pipe_pkg::*;
#(
  parameter int W_A = 6,
  parameter int W_B = 6,
  parameter int W_Y = 6,
  localparam int C  = ctx_width(W_A, W_B, W_Y)
) (
  input  logic [C-1:0]   a,
  input  logic [C-1:0]   b,
  input  op_e            op,
  input  logic [1:0]     sgn,
  output logic [W_Y-1:0] y,
  output logic           zero
);

  logic           both;
  logic           big;
  logic           lt;
  logic [W_B-1:0] shamt;
  logic [C-1:0]   a_zx;
  logic [C-1:0]   b_zx;
  logic [C-1:0]   ac;
  logic [C-1:0]   bc;
  logic [C-1:0]   res;

  // a/b arrive extended by their own sign flag; mixed signedness falls back to zero-extension
  always_comb begin
    a_zx = '0;
    a_zx[W_A-1:0] = a[W_A-1:0];
    b_zx = '0;
    b_zx[W_B-1:0] = b[W_B-1:0];
    both  = sgn[SGN_A] & sgn[SGN_B];
    ac    = both ? a : a_zx;
    bc    = both ? b : b_zx;
    shamt = b[W_B-1:0];
    big   = (32'(shamt) >= 32'(C));
    lt    = both ? ($signed(ac) < $signed(bc)) : (ac < bc);
    res   = '0;
    case (op)
      OP_ADD:   res = ac + bc;
      OP_SUB:   res = ac - bc;
      OP_AND:   res = ac & bc;
      OP_OR:    res = ac | bc;
      OP_XOR:   res = ac ^ bc;
      OP_XNOR:  res = ~(ac ^ bc);
      OP_SHL:   res = big ? '0 : (a << shamt);
      OP_SHR:   res = big ? '0 : (a >> shamt);
      OP_ASHR: begin
        if (sgn[SGN_A]) res = big ? {C{a[C-1]}} : C'($signed(a) >>> shamt);
        else            res = big ? '0 : (a >> shamt);
      end
      OP_LT:    res = C'(lt);
      OP_GE:    res = C'(!lt);
      OP_EQ:    res = C'(ac == bc);
      OP_NE:    res = C'(ac != bc);
      OP_LAND:  res = C'((|ac) && (|bc));
      OP_LOR:   res = C'((|ac) || (|bc));
      OP_RXNOR: res = C'(~^a[W_A-1:0]);
      default:  res = '0;
    endcase
    y    = res[W_Y-1:0];
    zero = (y == '0);
  end

endmodule

// File: rtl/expr_pipe_eval.sv
// Multi-lane expression evaluator with a two-stage valid/ready pipeline
// (S1 = extended operands, S2 = results) and a delivered-result counter.
module expr_pipe_eval
  import expr_pipe_pkg::*;
#(
  parameter int LANES = 3,
  parameter int W_A   = 6,
  parameter int W_B   = 6,
  parameter int W_Y   = 6,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*W_A-1:0] in_a,
  input  logic [LANES*W_B-1:0] in_b,
  input  logic [LANES*4-1:0]   in_op,
  input  logic [LANES*2-1:0]   in_sgn,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*W_Y-1:0] out_y,
  output logic [LANES-1:0]     out_zero,
  output logic [CNT_W-1:0]     out_cnt
);

  localparam int C = ctx_width(W_A, W_B, W_Y);

  logic s1_valid;
  logic s2_valid;
  logic s1_ready;
  logic s2_ready;

  logic [LANES-1:0][C-1:0] a_ext;
  logic [LANES-1:0][C-1:0] b_ext;
  logic [LANES-1:0][3:0]   op_in;
  logic [LANES-1:0][1:0]   sgn_in;
  logic [LANES-1:0][C-1:0] s1_a;
  logic [LANES-1:0][C-1:0] s1_b;
  logic [LANES-1:0][3:0]   s1_op;
  logic [LANES-1:0][1:0]   s1_sgn;
  logic [LANES*W_Y-1:0]    y_d;
  logic [LANES-1:0]        zero_d;

  assign s2_ready  = !s2_valid || out_ready;
  assign s1_ready  = !s1_valid || s2_ready;
  assign in_ready  = s1_ready;
  assign out_valid = s2_valid;

  // lane 0 occupies the most significant slice of every packed bus
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam int HI = LANES - 1 - i;
    logic [W_A-1:0] a_raw;
    logic [W_B-1:0] b_raw;

    assign a_raw     = in_a[HI*W_A +: W_A];
    assign b_raw     = in_b[HI*W_B +: W_B];
    assign op_in[i]  = in_op[HI*4 +: 4];
    assign sgn_in[i] = in_sgn[HI*2 +: 2];
    assign a_ext[i]  = sgn_in[i][SGN_A] ? C'($signed(a_raw)) : C'(a_raw);
    assign b_ext[i]  = sgn_in[i][SGN_B] ? C'($signed(b_raw)) : C'(b_raw);

    expr_pipe_lane #(
      .W_A(W_A),
      .W_B(W_B),
      .W_Y(W_Y)
    ) u_lane (
      .a   (s1_a[i]),
      .b   (s1_b[i]),
      .op  (op_e'(s1_op[i])),
      .sgn (s1_sgn[i]),
      .y   (y_d[HI*W_Y +: W_Y]),
      .zero(zero_d[HI])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
      s1_sgn   <= '0;
      s2_valid <= 1'b0;
      out_y    <= '0;
      out_zero <= '0;
    end else begin
      if (s1_ready) s1_valid <= in_valid;
      if (in_valid && s1_ready) begin
        s1_a   <= a_ext;
        s1_b   <= b_ext;
        s1_op  <= op_in;
        s1_sgn <= sgn_in;
      end
      // S2 data only changes when it is empty or being consumed, so a stalled beat holds
      if (s2_ready) s2_valid <= s1_valid;
      if (s1_valid && s2_ready) begin
        out_y    <= y_d;
        out_zero <= zero_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      out_cnt <= '0;
    else if (out_valid && out_ready) out_cnt <= out_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_expr_pipe_eval.sv
// Self-checking bench for expr_pipe_eval: directed scenarios plus a randomized
// stream compared against an integer-arithmetic reference model.
module tb_expr_pipe_eval;

  localparam int L   = 3;
  localparam int WA  = 6;
  localparam int WB  = 6;
  localparam int WY  = 6;
  localparam int CW  = 8;
  localparam int WAL = L * WA;
  localparam int WBL = L * WB;
  localparam int WYL = L * WY;
  localparam int OPL = L * 4;
  localparam int SGL = L * 2;

  typedef struct {
    logic [WAL-1:0] a;
    logic [WBL-1:0] b;
    logic [OPL-1:0] op;
    logic [SGL-1:0] sgn;
  } beat_t;

  typedef struct {
    logic [WYL-1:0] y;
    logic [L-1:0]   z;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [WAL-1:0] in_a = '0;
  logic [WBL-1:0] in_b = '0;
  logic [OPL-1:0] in_op = '0;
  logic [SGL-1:0] in_sgn = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [WYL-1:0] out_y;
  logic [L-1:0]   out_zero;
  logic [CW-1:0]  out_cnt;

  logic           in_valid6 = 1'b0;
  logic           in_ready6;
  logic [3:0]     a6 = '0;
  logic [4:0]     b6 = '0;
  logic [3:0]     op6 = '0;
  logic [1:0]     sgn6 = '0;
  logic           out_valid6;
  logic           out_ready6 = 1'b1;
  logic [7:0]     y6;
  logic [0:0]     zero6;
  logic [7:0]     cnt6;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  expr_pipe_eval #(.LANES(L), .W_A(WA), .W_B(WB), .W_Y(WY), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_sgn(in_sgn),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_zero(out_zero), .out_cnt(out_cnt)
  );

  expr_pipe_eval #(.LANES(1), .W_A(4), .W_B(5), .W_Y(8), .CNT_W(8)) dut6 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid6), .in_ready(in_ready6),
    .in_a(a6), .in_b(b6), .in_op(op6), .in_sgn(sgn6),
    .out_valid(out_valid6), .out_ready(out_ready6),
    .out_y(y6), .out_zero(zero6), .out_cnt(cnt6)
  );

  function automatic longint mask(input int w);
    return (longint'(1) << w) - 1;
  endfunction

  function automatic longint as_int(input longint raw, input int w, input bit s);
    longint v;
    v = raw & mask(w);
    if (s && v[w-1]) v = v - (longint'(1) << w);
    return v;
  endfunction

  // Integer model: operands become mathematical integers, results are taken modulo 2^wy
  function automatic longint ref_lane(input longint a, input longint b, input int op,
                                      input bit sa, input bit sb,
                                      input int wa, input int wb, input int wy);
    int c;
    bit both;
    longint av, bv, as_v, sh, r;
    c = wa;
    if (wb > c) c = wb;
    if (wy > c) c = wy;
    both = sa && sb;
    av   = as_int(a, wa, both);
    bv   = as_int(b, wb, both);
    as_v = as_int(a, wa, sa);
    sh   = b & mask(wb);
    if (sh > 63) sh = 63;
    case (op)
      0:  r = av + bv;
      1:  r = av - bv;
      2:  r = av & bv;
      3:  r = av | bv;
      4:  r = av ^ bv;
      5:  r = ~(av ^ bv);
      6:  r = (sh >= c) ? 0 : (as_v << sh);
      7:  r = (sh >= c) ? 0 : ((as_v & mask(c)) >> sh);
      8:  r = sa ? (as_v >>> sh) : ((sh >= c) ? 0 : ((as_v & mask(c)) >> sh));
      9:  r = (av < bv) ? 1 : 0;
      10: r = (av >= bv) ? 1 : 0;
      11: r = (av == bv) ? 1 : 0;
      12: r = (av != bv) ? 1 : 0;
      13: r = (av != 0 && bv != 0) ? 1 : 0;
      14: r = (av != 0 || bv != 0) ? 1 : 0;
      default: r = ($countones(a & mask(wa)) % 2 == 0) ? 1 : 0;
    endcase
    return r & mask(wy);
  endfunction

  function automatic res_t model(input beat_t bt);
    res_t r;
    r.y = '0;
    r.z = '0;
    for (int i = 0; i < L; i++) begin
      int hi;
      logic [1:0] s;
      longint v;
      hi = L - 1 - i;
      s  = bt.sgn[hi*2 +: 2];
      v  = ref_lane(longint'(bt.a[hi*WA +: WA]), longint'(bt.b[hi*WB +: WB]),
                    int'(bt.op[hi*4 +: 4]), s[1], s[0], WA, WB, WY);
      r.y[hi*WY +: WY] = WY'(v);
      r.z[hi] = (v == 0);
    end
    return r;
  endfunction

  function automatic beat_t rand_beat();
    beat_t bt;
    bt.a   = WAL'($urandom);
    bt.b   = WBL'($urandom);
    bt.op  = OPL'($urandom);
    bt.sgn = SGL'($urandom);
    return bt;
  endfunction

  task automatic put(input beat_t bt, input bit v);
    in_valid = v;
    in_a     = bt.a;
    in_b     = bt.b;
    in_op    = bt.op;
    in_sgn   = bt.sgn;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Offers one beat on an idle pipeline and waits (bounded) for its result
  task automatic send_and_get(input beat_t bt, output res_t got, output bit ok);
    ok = 1'b0;
    got.y = '0;
    got.z = '0;
    @(negedge clk);
    put(bt, 1'b1);
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (in_ready) break;
      @(negedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (out_valid) begin
        got.y = out_y;
        got.z = out_zero;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_out_valid: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_in_ready: got %b want 1", in_ready); end
    total++; if (out_cnt !== 8'd0) begin bad++; $display("[TB] FAIL rst_cnt: got %0d want 0", out_cnt); end
    total++; if (out_y !== '0) begin bad++; $display("[TB] FAIL rst_y: got %h want 0", out_y); end
    total++; if (out_zero !== '0) begin bad++; $display("[TB] FAIL rst_zero: got %b want 0", out_zero); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_lt();
    logic [1:0] sg [2];
    logic [5:0] want [2];
    sg[0] = 2'b11; want[0] = 6'd1;
    sg[1] = 2'b01; want[1] = 6'd0;
    for (int k = 0; k < 2; k++) begin
      beat_t bt;
      res_t  er;
      bt = rand_beat();
      bt.a[17:12]  = 6'h3E;
      bt.b[17:12]  = 6'h03;
      bt.op[11:8]  = 4'd9;
      bt.sgn[5:4]  = sg[k];
      er = model(bt);
      @(negedge clk);
      put(bt, 1'b1);
      out_ready = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL lt_in_ready: got %b want 1", in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL lt_early: got out_valid=%b want 0", out_valid); end
      @(negedge clk);
      #1;
      total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL lt_latency: got out_valid=%b want 1", out_valid); end
      total++; if (out_y[17:12] !== want[k]) begin bad++; $display("[TB] FAIL lt_lane0 sgn=%b: got %h want %h", sg[k], out_y[17:12], want[k]); end
      total++; if (out_y !== er.y || out_zero !== er.z) begin bad++; $display("[TB] FAIL lt_beat: got %h/%b want %h/%b", out_y, out_zero, er.y, er.z); end
    end
    @(negedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL lt_drain: got out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_shift();
    logic [5:0] ta [3];
    logic [5:0] tb [3];
    logic [3:0] top [3];
    logic [1:0] tsg [3];
    logic [5:0] ty [3];
    logic       tz [3];
    ta[0] = 6'h20; tb[0] = 6'd2; top[0] = 4'd8; tsg[0] = 2'b10; ty[0] = 6'h38; tz[0] = 1'b0;
    ta[1] = 6'h20; tb[1] = 6'd2; top[1] = 4'd8; tsg[1] = 2'b00; ty[1] = 6'h08; tz[1] = 1'b0;
    ta[2] = 6'h20; tb[2] = 6'd6; top[2] = 4'd6; tsg[2] = 2'b00; ty[2] = 6'h00; tz[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      beat_t bt;
      res_t  er, got;
      bit    ok;
      bt = rand_beat();
      bt.a[11:6]  = ta[k];
      bt.b[11:6]  = tb[k];
      bt.op[7:4]  = top[k];
      bt.sgn[3:2] = tsg[k];
      er = model(bt);
      send_and_get(bt, got, ok);
      total++; if (!ok) begin bad++; $display("[TB] FAIL shift_timeout case %0d: got no result want one", k); end
      total++; if (got.y[11:6] !== ty[k]) begin bad++; $display("[TB] FAIL shift_lane1 case %0d: got %h want %h", k, got.y[11:6], ty[k]); end
      total++; if (got.z[1] !== tz[k]) begin bad++; $display("[TB] FAIL shift_zero case %0d: got %b want %b", k, got.z[1], tz[k]); end
      total++; if (got.y !== er.y || got.z !== er.z) begin bad++; $display("[TB] FAIL shift_beat case %0d: got %h/%b want %h/%b", k, got.y, got.z, er.y, er.z); end
    end
  endtask

  task automatic test_back_to_back();
    beat_t bq [4];
    res_t  got [$];
    res_t  e0, e1, r;
    int    acc;
    acc = 0;
    for (int k = 0; k < 4; k++) bq[k] = rand_beat();
    e0 = model(bq[0]);
    e1 = model(bq[1]);
    @(negedge clk);
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      put(bq[acc], 1'b1);
      #1;
      if (in_ready) acc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    total++; if (acc != 2) begin bad++; $display("[TB] FAIL b2b_accepted: got %0d want 2", acc); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL b2b_in_ready: got %b want 0", in_ready); end
    total++; if (out_valid !== 1'b1 || out_y !== e0.y) begin bad++; $display("[TB] FAIL b2b_hold: got %b/%h want 1/%h", out_valid, out_y, e0.y); end
    @(negedge clk);
    #1;
    total++; if (out_y !== e0.y || out_zero !== e0.z) begin bad++; $display("[TB] FAIL b2b_stable: got %h/%b want %h/%b", out_y, out_zero, e0.y, e0.z); end
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (out_valid) begin
        r.y = out_y;
        r.z = out_zero;
        got.push_back(r);
      end
      @(negedge clk);
      #1;
    end
    total++; if (got.size() != 2) begin bad++; $display("[TB] FAIL b2b_count: got %0d want 2", got.size()); end
    if (got.size() >= 2) begin
      total++; if (got[0].y !== e0.y || got[0].z !== e0.z) begin bad++; $display("[TB] FAIL b2b_first: got %h want %h", got[0].y, e0.y); end
      total++; if (got[1].y !== e1.y || got[1].z !== e1.z) begin bad++; $display("[TB] FAIL b2b_second: got %h want %h", got[1].y, e1.y); end
    end
  endtask

  task automatic test_stream();
    res_t  q [$];
    res_t  er;
    beat_t cur;
    int    sent, cyc, delivered;
    sent = 0;
    cyc = 0;
    delivered = 0;
    apply_reset();
    while ((sent < 300 || q.size() > 0) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      cur = rand_beat();
      put(cur, (sent < 300) && ($urandom_range(3, 0) != 0));
      out_ready = 1'($urandom_range(1, 0));
      #1;
      if (out_valid && out_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("[TB] FAIL stream_extra: got %h want no beat", out_y);
        end else begin
          er = q.pop_front();
          if (out_y !== er.y || out_zero !== er.z) begin
            bad++; $display("[TB] FAIL stream_beat %0d: got %h/%b want %h/%b", delivered, out_y, out_zero, er.y, er.z);
          end
        end
        delivered++;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(cur));
        sent++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    total++; if (sent != 300 || q.size() != 0) begin bad++; $display("[TB] FAIL stream_timeout: got sent=%0d pending=%0d want 300/0", sent, q.size()); end
    total++; if (out_cnt !== 8'(delivered)) begin bad++; $display("[TB] FAIL stream_cnt_model: got %0d want %0d", out_cnt, 8'(delivered)); end
    total++; if (out_cnt !== 8'd44) begin bad++; $display("[TB] FAIL stream_cnt_wrap: got %0d want 44", out_cnt); end
  endtask

  task automatic test_mid_reset();
    beat_t b0, b1, b2;
    res_t  er, got;
    bit    ok;
    b0 = rand_beat();
    b1 = rand_beat();
    b2 = rand_beat();
    er = model(b2);
    @(negedge clk);
    out_ready = 1'b0;
    put(b0, 1'b1);
    @(negedge clk);
    put(b1, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL mr_inflight: got out_valid=%b want 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL mr_valid: got %b want 0", out_valid); end
    total++; if (out_cnt !== 8'd0) begin bad++; $display("[TB] FAIL mr_cnt: got %0d want 0", out_cnt); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL mr_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    send_and_get(b2, got, ok);
    total++; if (!ok || got.y !== er.y || got.z !== er.z) begin bad++; $display("[TB] FAIL mr_first: got ok=%b %h want %h", ok, got.y, er.y); end
    @(negedge clk);
    #1;
    total++; if (out_cnt !== 8'd1 || out_valid !== 1'b0) begin bad++; $display("[TB] FAIL mr_after: got cnt=%0d valid=%b want 1/0", out_cnt, out_valid); end
  endtask

  task automatic test_mixed();
    for (int k = 0; k < 9; k++) begin
      logic [7:0] want, gy;
      logic       gz;
      bit         got;
      @(negedge clk);
      if (k == 0) begin
        a6 = 4'hF; b6 = 5'h01; op6 = 4'd0; sgn6 = 2'b10;
      end else begin
        a6 = 4'($urandom); b6 = 5'($urandom); op6 = 4'($urandom); sgn6 = 2'($urandom);
      end
      want = 8'(ref_lane(longint'(a6), longint'(b6), int'(op6), sgn6[1], sgn6[0], 4, 5, 8));
      in_valid6 = 1'b1;
      out_ready6 = 1'b1;
      for (int t = 0; t < 20; t++) begin
        #1;
        if (in_ready6) break;
        @(negedge clk);
      end
      @(negedge clk);
      in_valid6 = 1'b0;
      got = 1'b0;
      gy = '0;
      gz = 1'b0;
      for (int t = 0; t < 20; t++) begin
        #1;
        if (out_valid6) begin got = 1'b1; gy = y6; gz = zero6[0]; break; end
        @(negedge clk);
      end
      total++; if (!got || gy !== want || gz !== (want == 8'd0)) begin
        bad++; $display("[TB] FAIL mixed case %0d: got ok=%b %h/%b want %h/%b", k, got, gy, gz, want, (want == 8'd0));
      end
      if (k == 0) begin
        total++; if (gy !== 8'h10) begin bad++; $display("[TB] FAIL mixed_add: got %h want 10", gy); end
      end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_lt();
    test_shift();
    test_back_to_back();
    test_stream();
    test_mid_reset();
    test_mixed();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
